// File: rtl/cpu_rf_pkg.sv
// rtl/cpu_rf_pkg.sv - shared widths, register-zero constant and write-source enum for the RF writeback path
package cpu_rf_pkg;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {WB_NONE, WB_ALU, WB_LSU} wb_src_e;
endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - DEPTH-entry result FIFO; pointers carry one extra wrap bit so full/empty need no counter
module wb_fifo #(
  parameter int W     = 37,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push && !full)  wptr <= wptr + PW'(1);
      if (pop && !empty)  rptr <= rptr + PW'(1);
    end
  end

  // Storage is not reset; entries are only ever read between the pointers.
  always_ff @(posedge clk) begin
    if (push && !full) mem[wptr[IW-1:0]] <= wdata;
  end

  assign rdata = mem[rptr[IW-1:0]];
  assign empty = (wptr == rptr);
  assign full  = ((wptr - rptr) == PW'(DEPTH));
endmodule

// File: rtl/rf_writeback.sv
// rtl/rf_writeback.sv - merges ALU and LSU/MDU results onto the single RF write port,
// tracks pending long-latency destinations and provides decode-stage stall/forwarding
module rf_writeback #(
  parameter int DW    = cpu_rf_pkg::DW,
  parameter int AW    = cpu_rf_pkg::AW,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          alu_valid,
  input  logic [AW-1:0] alu_rw,
  input  logic [DW-1:0] alu_data,
  input  logic          lsu_valid,
  output logic          lsu_ready,
  input  logic [AW-1:0] lsu_rw,
  input  logic [DW-1:0] lsu_data,
  input  logic          iss_valid,
  input  logic [AW-1:0] iss_rw,
  input  logic [AW-1:0] ra,
  input  logic [AW-1:0] rb,
  output logic          stall_a,
  output logic          stall_b,
  output logic          fwd_a_hit,
  output logic          fwd_b_hit,
  output logic [DW-1:0] fwd_a,
  output logic [DW-1:0] fwd_b,
  output logic          we,
  output logic [AW-1:0] rw,
  output logic [DW-1:0] rd
);
  import cpu_rf_pkg::*;

  localparam int EW = AW + DW;
  localparam int NR = 1 << AW;
  localparam logic [AW-1:0] RZ = AW'(REG_ZERO);

  logic [EW-1:0] head;
  logic [AW-1:0] head_rw;
  logic [DW-1:0] head_data;
  logic          fifo_full;
  logic          fifo_empty;
  logic          push;
  logic          pop;
  wb_src_e       sel;
  logic [NR-1:0] pending;
  logic [NR-1:0] pending_nxt;

  assign lsu_ready = !clr && !fifo_full;
  assign push      = lsu_valid && lsu_ready;
  assign head_rw   = head[EW-1:DW];
  assign head_data = head[DW-1:0];

  wb_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .clr   (clr),
    .push  (push),
    .pop   (pop),
    .wdata ({lsu_rw, lsu_data}),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // ALU has fixed priority; a write to r0 is dropped and frees the port for the FIFO.
  always_comb begin
    sel = WB_NONE;
    if (alu_valid && (alu_rw != RZ)) sel = WB_ALU;
    else if (!fifo_empty)            sel = WB_LSU;
  end

  assign pop = (sel == WB_LSU);

  // Clear on pop first so a same-cycle issue to the same register wins.
  always_comb begin
    pending_nxt = pending;
    if (pop) pending_nxt[head_rw] = 1'b0;
    if (iss_valid && (iss_rw != RZ)) pending_nxt[iss_rw] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      we      <= 1'b0;
      rw      <= '0;
      rd      <= '0;
      pending <= '0;
    end else begin
      pending <= pending_nxt;
      case (sel)
        WB_ALU: begin
          we <= 1'b1;
          rw <= alu_rw;
          rd <= alu_data;
        end
        WB_LSU: begin
          we <= (head_rw != RZ);
          rw <= head_rw;
          rd <= head_data;
        end
        default: we <= 1'b0;
      endcase
    end
  end

  assign stall_a   = pending[ra] && (ra != RZ);
  assign stall_b   = pending[rb] && (rb != RZ);
  assign fwd_a_hit = we && (rw == ra) && (ra != RZ);
  assign fwd_b_hit = we && (rw == rb) && (rb != RZ);
  assign fwd_a     = fwd_a_hit ? rd : '0;
  assign fwd_b     = fwd_b_hit ? rd : '0;
endmodule

// File: tb/tb_rf_writeback.sv
// tb/tb_rf_writeback.sv - directed scenarios plus random traffic against a queue/array reference model
module tb_rf_writeback;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int DEPTH = 4;
  localparam int NR = 1 << AW;

  logic          clk = 1'b0;
  logic          clr = 1'b0;
  logic          alu_valid = 1'b0;
  logic [AW-1:0] alu_rw = '0;
  logic [DW-1:0] alu_data = '0;
  logic          lsu_valid = 1'b0;
  logic          lsu_ready;
  logic [AW-1:0] lsu_rw = '0;
  logic [DW-1:0] lsu_data = '0;
  logic          iss_valid = 1'b0;
  logic [AW-1:0] iss_rw = '0;
  logic [AW-1:0] ra = '0;
  logic [AW-1:0] rb = '0;
  logic          stall_a, stall_b, fwd_a_hit, fwd_b_hit, we;
  logic [DW-1:0] fwd_a, fwd_b, rd;
  logic [AW-1:0] rw;

  always #5 clk = ~clk;

  rf_writeback #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .clr(clr),
    .alu_valid(alu_valid), .alu_rw(alu_rw), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rw(lsu_rw), .lsu_data(lsu_data),
    .iss_valid(iss_valid), .iss_rw(iss_rw), .ra(ra), .rb(rb),
    .stall_a(stall_a), .stall_b(stall_b), .fwd_a_hit(fwd_a_hit), .fwd_b_hit(fwd_b_hit),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .we(we), .rw(rw), .rd(rd)
  );

  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic [AW-1:0] rw;
    logic [DW-1:0] d;
  } ent_t;

  // Reference state always describes the DUT as it is after the most recent posedge.
  ent_t          q[$];
  bit            pend[NR];
  bit            m_we = 1'b0;
  logic [AW-1:0] m_rw = '0;
  logic [DW-1:0] m_rd = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    bit   take, popd, pushable;
    ent_t e;
    if (clr) begin
      chk("rst_we", we, 0);
      chk("rst_rw", rw, 0);
      chk("rst_rd", rd, 0);
      chk("rst_ready", lsu_ready, 0);
      chk("rst_stall", {stall_a, stall_b}, 0);
      chk("rst_fwd", {fwd_a_hit, fwd_b_hit}, 0);
      q.delete();
      foreach (pend[i]) pend[i] = 1'b0;
      m_we = 1'b0;
      m_rw = '0;
      m_rd = '0;
    end else begin
      chk("ready", lsu_ready, q.size() != DEPTH);
      chk("we", we, m_we);
      if (m_we) begin
        chk("rw", rw, m_rw);
        chk("rd", rd, m_rd);
      end
      chk("stall_a", stall_a, (ra != 0) && pend[ra]);
      chk("stall_b", stall_b, (rb != 0) && pend[rb]);
      chk("fwd_a_hit", fwd_a_hit, m_we && (m_rw == ra) && (ra != 0));
      chk("fwd_b_hit", fwd_b_hit, m_we && (m_rw == rb) && (rb != 0));
      chk("fwd_a", fwd_a, (m_we && (m_rw == ra) && (ra != 0)) ? m_rd : 0);
      chk("fwd_b", fwd_b, (m_we && (m_rw == rb) && (rb != 0)) ? m_rd : 0);
      total++;
      assert (!(alu_valid && (alu_rw != 0) && pend[alu_rw])) else begin
        bad++;
        $display("FAIL waw rw=%0d act=pending exp=clear @%0t", alu_rw, $time);
      end

      take     = alu_valid && (alu_rw != 0);
      popd     = !take && (q.size() > 0);
      pushable = lsu_valid && (q.size() != DEPTH);
      if (take) begin
        m_we = 1'b1;
        m_rw = alu_rw;
        m_rd = alu_data;
      end else if (popd) begin
        e = q.pop_front();
        m_we = (e.rw != 0);
        m_rw = e.rw;
        m_rd = e.d;
        pend[e.rw] = 1'b0;
      end else begin
        m_we = 1'b0;
      end
      if (pushable) q.push_back({lsu_rw, lsu_data});
      if (iss_valid && (iss_rw != 0)) pend[iss_rw] = 1'b1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_valid = 1'b0;
    lsu_valid = 1'b0;
    iss_valid = 1'b0;
  endtask

  initial begin
    #1 clr = 1'b1;
    #1;
    chk("init_we", we, 0);
    chk("init_ready", lsu_ready, 0);
    step();
    step();
    clr = 1'b0;
    #1;
    chk("rel_ready", lsu_ready, 1);
    chk("rel_we", we, 0);

    // clr with three entries parked behind a busy ALU
    for (int i = 0; i < 3; i++) begin
      alu_valid = 1'b1; alu_rw = AW'(20 + i); alu_data = DW'(32'h3000 + i);
      lsu_valid = 1'b1; lsu_rw = AW'(1 + i);  lsu_data = DW'(32'hA0 + i);
      step();
    end
    idle();
    chk("t1_model_q", q.size(), 3);
    clr = 1'b1;
    #1;
    chk("t1_we", we, 0);
    chk("t1_ready", lsu_ready, 0);
    step();
    clr = 1'b0;
    #1;
    chk("t1_ready_after", lsu_ready, 1);
    step();
    chk("t1_we_after", we, 0);
    step();
    chk("t1_we_after2", we, 0);

    // ALU single-cycle latency and forwarding
    alu_valid = 1'b1; alu_rw = 5; alu_data = 32'h1234; ra = 5;
    step();
    idle();
    #1;
    chk("t2_we", we, 1);
    chk("t2_rw", rw, 5);
    chk("t2_rd", rd, 32'h1234);
    chk("t2_fwd_hit", fwd_a_hit, 1);
    chk("t2_fwd", fwd_a, 32'h1234);
    chk("t2_model_we", m_we, 1);

    // issue, later LSU result: stall until pop, forward on the write
    step();
    ra = 8; iss_valid = 1'b1; iss_rw = 8;
    step();
    iss_valid = 1'b0;
    #1;
    chk("t3_stall", stall_a, 1);
    chk("t3_model_pend", pend[8], 1);
    step();
    lsu_valid = 1'b1; lsu_rw = 8; lsu_data = 32'hBEEF;
    step();
    lsu_valid = 1'b0;
    #1;
    chk("t3_stall_pop", stall_a, 1);
    step();
    chk("t3_we", we, 1);
    chk("t3_rw", rw, 8);
    chk("t3_rd", rd, 32'hBEEF);
    chk("t3_fwd_hit", fwd_a_hit, 1);
    chk("t3_fwd", fwd_a, 32'hBEEF);
    chk("t3_stall_clr", stall_a, 0);

    // ALU busy six cycles while the FIFO fills, then drains in order
    ra = 0;
    for (int k = 0; k <= 10; k++) begin
      alu_valid = (k < 6); alu_rw = AW'(10 + k); alu_data = DW'(32'h100 + k);
      lsu_valid = (k < 4); lsu_rw = AW'(16 + k); lsu_data = DW'(32'h200 + k);
      #1;
      if (k == 4) chk("t4_ready_full", lsu_ready, 0);
      if (k >= 1 && k <= 6) begin
        chk("t4_alu_we", we, 1);
        chk("t4_alu_rw", rw, 10 + k - 1);
      end
      if (k >= 7) begin
        chk("t4_lsu_we", we, 1);
        chk("t4_lsu_rw", rw, 16 + k - 7);
        chk("t4_lsu_rd", rd, 32'h200 + k - 7);
      end
      step();
    end
    idle();

    // issue and pop of the same register in one cycle: set wins
    lsu_valid = 1'b1; lsu_rw = 9; lsu_data = 32'h99;
    step();
    lsu_valid = 1'b0; iss_valid = 1'b1; iss_rw = 9; ra = 9;
    step();
    iss_valid = 1'b0;
    #1;
    chk("t5_we", we, 1);
    chk("t5_rw", rw, 9);
    chk("t5_stall", stall_a, 1);
    chk("t5_model_pend", pend[9], 1);

    // ALU to r0 yields the port; an r0 FIFO entry pops with no write
    ra = 0;
    step();
    lsu_valid = 1'b1; lsu_rw = 7; lsu_data = 32'h77;
    step();
    lsu_valid = 1'b1; lsu_rw = 0; lsu_data = 32'h55;
    alu_valid = 1'b1; alu_rw = 0; alu_data = 32'hDEAD;
    step();
    idle();
    #1;
    chk("t6_we", we, 1);
    chk("t6_rw", rw, 7);
    chk("t6_rd", rd, 32'h77);
    step();
    chk("t6_r0_we", we, 0);

    for (int n = 0; n < 3000; n++) begin
      step();
      if (clr) clr = 1'b0;
      else if ($urandom_range(0, 399) == 0) clr = 1'b1;
      iss_valid = ($urandom_range(0, 3) == 0);
      iss_rw    = AW'($urandom);
      alu_valid = $urandom_range(0, 1);
      alu_rw    = AW'($urandom);
      if (pend[alu_rw]) alu_rw = '0;
      alu_data  = $urandom;
      lsu_valid = ($urandom_range(0, 2) != 0);
      lsu_rw    = AW'($urandom);
      lsu_data  = $urandom;
      ra = $urandom_range(0, 1) ? m_rw : AW'($urandom);
      rb = AW'($urandom);
    end
    idle();
    clr = 1'b0;
    repeat (10) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
